// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types and helpers for the sequential binary-to-BCD
//                converter. It holds the converter state encoding, the BCD
//                digit width and the leading-zero blank-mask function used by
//                the 7-segment display path.
//  Contents    : state_e       - converter FSM states (IDLE, SHIFT, DONE)
//                BCD_DIGIT_W   - bits per packed BCD digit
//                MAX_DIGITS    - largest digit count blank_mask() handles
//                blank_mask()  - leading-zero mask from packed digits
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;

  // Upper bound on the digit count that blank_mask() can work on. Callers
  // zero-extend their digit vector to this size and truncate the result.
  localparam int MAX_DIGITS = 16;

  // Bit k (k >= 1) is set when digits k..n_digits-1 are all zero. Bit 0 is
  // always clear so that a value of zero still shows a single "0".
  // The scan runs from the most significant digit downwards, so the running
  // "everything above is zero" flag can be reused for each lower digit.
  function automatic logic [MAX_DIGITS-1:0] blank_mask(
    input logic [BCD_DIGIT_W*MAX_DIGITS-1:0] digits,
    input int                                n_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < n_digits) begin
        zero_above = zero_above &
                     (digits[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
        mask[k]    = zero_above;
      end
    end
    return mask;
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Double-dabble digit correction. Adds 3 to a BCD digit that
//                is 5 or more so that the following left shift carries into
//                the next decimal digit correctly. Purely combinational.
//  Ports       : digit_i  in  4  scratch digit before correction
//                digit_o  out 4  digit + 3 when digit_i >= 5, else digit_i
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Scratch digits never exceed 9 during a conversion, so the sum tops out
  // at 12 and fits the 4-bit result without wrapping.
  always_comb begin
    if (digit_i >= BCD_DIGIT_W'(5)) begin
      digit_o = digit_i + BCD_DIGIT_W'(3);
    end else begin
      digit_o = digit_i;
    end
  end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Iterative (double-dabble) binary to packed-BCD converter for
//                the display path. One input bit is consumed per cycle; a
//                result is produced WIDTH+1 cycles after start is accepted.
//                Values that do not fit DIGITS decimal digits raise ovf and
//                leave the value modulo 10^DIGITS on bcd_o.
//  Parameters  : WIDTH   - binary input width (>= 1)
//                DIGITS  - number of BCD digits produced (1..MAX_DIGITS)
//  Ports       : clk_i    in  1         clock, rising edge
//                reset_i  in  1         synchronous active-high reset
//                start_i  in  1         request a conversion (IDLE only)
//                bin_i    in  WIDTH     value sampled on the accepting cycle
//                busy_o   out 1         high in SHIFT and DONE
//                done_o   out 1         one-cycle result pulse
//                bcd_o    out 4*DIGITS  digit k in [4k+3:4k]
//                ovf_o    out 1         value >= 10^DIGITS
//                blank_o  out DIGITS    leading-zero mask, bit 0 always 0
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [WIDTH-1:0]              bin_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                          ovf_o,
  output logic [DIGITS-1:0]             blank_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DIG_W = BCD_DIGIT_W * DIGITS;
  localparam int CAT_W = DIG_W + WIDTH + 1;

  // Reset display shows a single "0": every digit blanked except the units.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;   // remaining binary bits
  logic [DIG_W-1:0]   dig_q,   dig_d;     // scratch BCD digits
  logic               ovfs_q,  ovfs_d;    // sticky overflow scratch
  logic [CNT_W-1:0]   cnt_q,   cnt_d;     // shifts still to perform
  logic [DIG_W-1:0]   bcd_q,   bcd_d;
  logic               ovf_q,   ovf_d;
  logic [DIGITS-1:0]  blank_q, blank_d;

  // --------------------------------------------------------------------------
  // Per-digit add-3 correction
  // --------------------------------------------------------------------------
  logic [DIG_W-1:0] w_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (dig_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (w_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // --------------------------------------------------------------------------
  // One shift step of {digits, shift register}
  // --------------------------------------------------------------------------
  // The trailing zero makes the concatenation already appear shifted left by
  // one: its top bit is the bit leaving the most significant digit, the next
  // DIG_W bits are the new digits and the low WIDTH bits the new shift
  // register. This avoids a separate slice of shift_q, which would be empty
  // when WIDTH is 1.
  logic [CAT_W-1:0]  w_cat;
  logic              w_carry;
  logic [DIG_W-1:0]  w_dig_sh;
  logic [WIDTH-1:0]  w_shift_sh;
  logic [DIGITS-1:0] w_blank_sh;

  assign w_cat      = {w_adj, shift_q, 1'b0};
  assign w_carry    = w_cat[CAT_W-1];
  assign w_dig_sh   = w_cat[WIDTH +: DIG_W];
  assign w_shift_sh = w_cat[WIDTH-1:0];
  assign w_blank_sh = DIGITS'(blank_mask((BCD_DIGIT_W*MAX_DIGITS)'(w_dig_sh),
                                         DIGITS));

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dig_d   = dig_q;
    ovfs_d  = ovfs_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shift_d = bin_i;
          dig_d   = '0;
          ovfs_d  = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        dig_d   = w_dig_sh;
        shift_d = w_shift_sh;
        ovfs_d  = ovfs_q | w_carry;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          // The result registers are loaded on the edge into DONE, so the
          // new values are already visible in the cycle that carries the
          // done pulse. They are not touched again until the next final
          // shift, which keeps them stable across later conversions.
          bcd_d   = w_dig_sh;
          ovf_d   = ovfs_q | w_carry;
          blank_d = w_blank_sh;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      dig_q   <= '0;
      ovfs_q  <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      blank_q <= BLANK_RST;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dig_q   <= dig_d;
      ovfs_q  <= ovfs_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
    end
  end

  // Status flags are plain decodes of the state register.
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;
  assign blank_o = blank_q;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq. Two instances are
//                exercised (WIDTH=8 and WIDTH=10, both DIGITS=3). Expected
//                results come from a decimal reference model and are queued
//                at issue time; per-instance monitors compare on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    logic [2:0]  blank;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  logic        start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;
  logic [2:0]  blank8;

  logic        start10 = 1'b0;
  logic [9:0]  bin10 = '0;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd10;
  logic [2:0]  blank10;

  exp_t q8[$];
  exp_t q10[$];
  int   free8 = 0;
  int   free10 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk_i(clk), .reset_i(rst), .start_i(start8), .bin_i(bin8),
    .busy_o(busy8), .done_o(done8), .bcd_o(bcd8), .ovf_o(ovf8),
    .blank_o(blank8)
  );

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) u_dut10 (
    .clk_i(clk), .reset_i(rst), .start_i(start10), .bin_i(bin10),
    .busy_o(busy10), .done_o(done10), .bcd_o(bcd10), .ovf_o(ovf10),
    .blank_o(blank10)
  );

  // Decimal reference: digits of v mod 1000, overflow when v >= 1000,
  // digit k blanked when the kept value is below 10^k.
  function automatic exp_t model(input int unsigned v, input int issue_cyc);
    exp_t        e;
    int unsigned r;
    int unsigned pw;
    r       = v % 1000;
    e.ovf   = (v >= 1000);
    e.bcd   = '0;
    e.blank = '0;
    e.cyc   = issue_cyc;
    pw      = 1;
    for (int k = 0; k < 3; k++) begin
      e.bcd[4*k +: 4] = 4'((r / pw) % 10);
      if (k > 0) e.blank[k] = (r < pw);
      pw = pw * 10;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ------------------------------------------------------------------
  // Monitors
  // ------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("bcd8", 32'(bcd8), 32'(e.bcd));
        chk("ovf8", 32'(ovf8), 32'(e.ovf));
        chk("blank8", 32'(blank8), 32'(e.blank));
        chk("latency8", 32'(cyc - e.cyc), 32'd9);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done10) begin
      if (q10.size() == 0) begin
        chk("unexpected_done10", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q10.pop_front();
        chk("bcd10", 32'(bcd10), 32'(e.bcd));
        chk("ovf10", 32'(ovf10), 32'(e.ovf));
        chk("blank10", 32'(blank10), 32'(e.blank));
        chk("latency10", 32'(cyc - e.cyc), 32'd11);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after a rising edge)
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go8(input int unsigned v);
    bin8   = 8'(v);
    start8 = 1'b1;
    if (cyc >= free8) begin
      q8.push_back(model(v, cyc));
      free8 = cyc + 10;
    end
    step();
    start8 = 1'b0;
    bin8   = 8'($urandom);
  endtask

  task automatic go10(input int unsigned v);
    bin10   = 10'(v);
    start10 = 1'b1;
    if (cyc >= free10) begin
      q10.push_back(model(v, cyc));
      free10 = cyc + 12;
    end
    step();
    start10 = 1'b0;
    bin10   = 10'($urandom);
  endtask

  task automatic idle8();
    while (cyc < free8) step();
  endtask

  task automatic idle10();
    while (cyc < free10) step();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q8.size() != 0 || q10.size() != 0) && t < 300) begin
      step();
      t++;
    end
    chk("drain8_empty", 32'(q8.size()), 32'd0);
    chk("drain10_empty", 32'(q10.size()), 32'd0);
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_bcd", 32'(bcd8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    chk("rst_blank", 32'(blank8), 32'b110);
    chk("rst_blank10", 32'(blank10), 32'b110);
    step();

    // 255: busy for cycles 1..9, done exactly at cycle 9.
    go8(255);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("busy255_c%0d", i), 32'(busy8), 32'(i <= 9));
      chk($sformatf("done255_c%0d", i), 32'(done8), 32'(i == 9));
    end
    step();

    // Blank-mask boundaries.
    idle8(); go8(0);
    idle8(); go8(7);
    idle8(); go8(40);
    idle8(); go8(100);

    // Starts while busy are ignored; start on cycle WIDTH+2 is accepted.
    idle8();
    go8(200);
    step();
    start8 = 1'b1;
    bin8   = 8'd12;
    repeat (4) step();
    start8 = 1'b0;
    idle8();
    go8(12);
    idle8();

    // Reset in cycle 4 of a conversion aborts it without a done pulse.
    go8(255);
    repeat (3) step();
    rst = 1'b1;
    q8.delete();
    free8 = 0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_bcd", 32'(bcd8), 32'd0);
    chk("abort_ovf", 32'(ovf8), 32'd0);
    chk("abort_blank", 32'(blank8), 32'b110);
    step();
    go8(128);
    idle8();

    // WIDTH=10: overflow handling and the 999/1000 boundary.
    go10(1023); idle10();
    go10(999);  idle10();
    go10(1000); idle10();
    go10(0);    idle10();

    // Randomised sweeps on both instances, run concurrently.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle8();
          repeat ($urandom_range(0, 2)) step();
          go8($urandom_range(0, 255));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          idle10();
          repeat ($urandom_range(0, 2)) step();
          go10($urandom_range(0, 1023));
        end
      end
    join

    drain();
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential, parametrised binary-to-decimal converter for the display path. It takes a WIDTH-bit unsigned value and converts it to DIGITS packed BCD digits using an iterative shift-and-add-3 (double-dabble) loop. It reports overflow when the value exceeds the digit range and provides a leading-zero blank mask for the 7-segment driver. It sits between the datapath result registers and the digit multiplexer, replacing fixed-width combinational converters.

## Interface
- WIDTH, 8, bit width of the binary input (≥1).
- DIGITS, 3, number of BCD digits produced (≥1).
- clk  in  1  sole clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- start  in  1  request conversion of `bin`; honoured only in IDLE.
- bin  in  WIDTH  unsigned value; sampled only on the accepting cycle.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- bcd  out  4*DIGITS  result; digit 0 (units) in [3:0], digit k in [4k+3:4k].
- ovf  out  1  the value was ≥ 10^DIGITS; `bcd` then holds value mod 10^DIGITS.
- blank  out  DIGITS  bit k = 1 if digit k is a leading zero; bit 0 is always 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load shift register ← bin, digit scratch ← 0, ovf scratch ← 0, counter ← WIDTH; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each cycle:
  - Every scratch digit ≥5 gets +3.
  - The whole {digits, shift register} is then shifted left by 1.
  - The bit shifted out of the top digit is ORed into ovf scratch.
  - Counter decrements. When the counter reaches 0 after the decrement, go to DONE.
- DONE, exactly one cycle:
  - bcd ← scratch digits, ovf ← ovf scratch, blank ← computed mask.
  - done=1; go to IDLE.
- Blank mask: bit k (k≥1) = 1 if digits k..DIGITS-1 are all zero.
- Outputs `bcd`, `ovf` and `blank` hold their value until the next DONE. They never change mid-conversion.
- start while busy: ignored, no queuing. `bin` changes after acceptance have no effect.
- Arithmetic:
  - Digit adjust is 4-bit unsigned; +3 on a value of 5..9 never exceeds 12.
  - Counter width is $clog2(WIDTH+1).
- Reset values: state IDLE, busy=0, done=0, bcd=0, ovf=0, blank = all ones except bit 0 = 0 (displays "0").
- Reset mid-conversion: the conversion is aborted with no done pulse, and all outputs take their reset values.
- reset and start in the same cycle: reset wins, and start is not remembered.

## Timing
- Cycle 0: start accepted in IDLE.
- Cycles 1..WIDTH: SHIFT; busy=1.
- Cycle WIDTH+1: DONE; done=1, busy=1, new outputs visible.
- Cycle WIDTH+2: IDLE; the earliest cycle a new start is accepted.
- Latency start→done is WIDTH+1 cycles. Throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `bcd_pkg`:
  - state enum (IDLE, SHIFT, DONE);
  - constant BCD_DIGIT_W = 4;
  - function computing the blank mask from a packed digit vector.
- Sub-module `bcd_digit_adj`: combinational; input 4 bits; output the input +3 if ≥5, else the input unchanged. Instantiated DIGITS times in a generate loop.
- The top level holds the FSM, counter, shift/scratch registers and output registers.

## Test plan
- WIDTH=8, DIGITS=3, bin=255, start pulse → done at cycle 9; bcd=12'h255, ovf=0, blank=3'b000; busy high for cycles 1–9.
- bin=0 → bcd=12'h000, blank=3'b110, ovf=0; bin=7 → bcd=12'h007, blank=3'b110; bin=40 → bcd=12'h040, blank=3'b100.
- WIDTH=10, DIGITS=3, bin=1023 → bcd=12'h023, ovf=1; then bin=999 → bcd=12'h999, ovf=0.
- start=1 with bin=12 in cycles 2–5 of a conversion of 200 → only one done, with bcd=12'h200; start asserted on cycle WIDTH+2 with bin=12 → accepted, result 12'h012.
- reset asserted in cycle 4 of a conversion of 255 → no done pulse; next cycle busy=0, bcd=0, blank=3'b110. A subsequent conversion of 128 gives 12'h128.
- Randomised sweep of bin over 0..2^WIDTH-1 → bcd matches the decimal digits of bin mod 10^DIGITS, ovf = (bin ≥ 10^DIGITS), and latency is always WIDTH+1.
